liteic_master_node_write: RTL and testbench

Per-master write node of the lite interconnect. It accepts AXI-Lite write transactions from one master port and decodes AW address to a slave slot. It forwards AW and W to that slot's slave write node through the crossbar request lines, collects the slot's B response, and returns it to the master. At most one write is outstanding per master. Unmapped addresses are terminated locally with DECERR.

---
 rtl/liteic_master_node_write_if.sv | 36 +++
 rtl/liteic_master_node_write.sv | 223 ++++++++++++++++++++++
 tb/tb_liteic_master_node_write.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/liteic_master_node_write_if.sv
// axi_lite_if
//   AXI-Lite write-channel bundle (AW, W, B) between a master and the
//   interconnect's per-master write node.
//   Signals:
//     aw_valid/aw_ready/aw_addr       write address channel
//     w_valid/w_ready/w_data/w_strb   write data channel
//     b_valid/b_ready/b_resp          write response channel
//   Modports:
//     mst - the requesting master (drives AW/W payload, B ready)
//     slv - the subordinate side (drives AW/W ready, B valid/resp)
interface axi_lite_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RESP_W = 2
);
   logic                aw_valid;
   logic                aw_ready;
   logic [ADDR_W-1:0]   aw_addr;
   logic                w_valid;
   logic                w_ready;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                b_valid;
   logic                b_ready;
   logic [RESP_W-1:0]   b_resp;

   modport mst (
      output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      input  aw_ready, w_ready, b_valid, b_resp
   );

   modport slv (
      input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      output aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/liteic_master_node_write.sv
// liteic_master_node_write
//   Per-master write node of the lite interconnect. Accepts one AXI-Lite
//   write at a time from the master, decodes the AW address to a crossbar
//   slave slot, forwards AW and W to that slot, waits for the slot's B
//   response and returns it to the master. Addresses that match no slot
//   are completed locally with DECERR once the W beat has been taken.
//
//   Ports:
//     clk_i, rstn_i              clock (rising edge), async active-low reset
//     mst_axil                   master AW/W/B channels (subordinate side)
//     cbar_aw_reqst_data_o       latched AW address, broadcast to every slot
//     cbar_aw_reqst_val_o        one-hot AW valid toward the selected slot
//     cbar_aw_reqst_rdy_i        per-slot AW ready
//     cbar_w_reqst_data_o        latched {strb,data}, broadcast to every slot
//     cbar_w_reqst_val_o         one-hot W valid toward the selected slot
//     cbar_w_reqst_rdy_i         per-slot W ready
//     cbar_resp_val_i            per-slot B valid
//     cbar_resp_data_i           per-slot B response
//     cbar_resp_rdy_o            one-hot B ready toward the selected slot
module liteic_master_node_write #(
   parameter int unsigned IC_NUM_SLAVE_SLOTS = 4,
   parameter int unsigned IC_AWADDR_WIDTH    = 32,
   parameter int unsigned IC_WDATA_WIDTH     = 36,
   parameter int unsigned IC_BRESP_WIDTH     = 2,
   parameter logic [IC_NUM_SLAVE_SLOTS-1:0][IC_AWADDR_WIDTH-1:0] IC_SLAVE_BASE_ADDR =
      {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [IC_NUM_SLAVE_SLOTS-1:0][IC_AWADDR_WIDTH-1:0] IC_SLAVE_ADDR_MASK =
      {4{32'hF000_0000}}
) (
   input  logic                                                  clk_i,
   input  logic                                                  rstn_i,
   axi_lite_if.slv                                               mst_axil,
   output logic [IC_NUM_SLAVE_SLOTS-1:0][IC_AWADDR_WIDTH-1:0]   cbar_aw_reqst_data_o,
   output logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_aw_reqst_val_o,
   input  logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_aw_reqst_rdy_i,
   output logic [IC_NUM_SLAVE_SLOTS-1:0][IC_WDATA_WIDTH-1:0]    cbar_w_reqst_data_o,
   output logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_w_reqst_val_o,
   input  logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_w_reqst_rdy_i,
   input  logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_resp_val_i,
   input  logic [IC_NUM_SLAVE_SLOTS-1:0][IC_BRESP_WIDTH-1:0]    cbar_resp_data_i,
   output logic [IC_NUM_SLAVE_SLOTS-1:0]                        cbar_resp_rdy_o
);

   localparam int unsigned NS = IC_NUM_SLAVE_SLOTS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_DECERR,
      ST_RESP,
      ST_BRESP
   } state_e;

   state_e                       state_q, state_d;
   logic [IC_AWADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [NS-1:0]                sel_q,   sel_d;
   logic [IC_WDATA_WIDTH-1:0]    wbuf_q,  wbuf_d;
   logic                         w_full_q,  w_full_d;
   logic                         aw_done_q, aw_done_d;
   logic                         w_done_q,  w_done_d;
   logic [IC_BRESP_WIDTH-1:0]    bresp_q, bresp_d;

   logic [NS-1:0]                dec_sel;
   logic                         dec_hit;
   logic [IC_BRESP_WIDTH-1:0]    resp_mux;

   logic                         aw_ready, w_ready, b_valid;
   logic [NS-1:0]                aw_val, w_val, resp_rdy;
   logic                         aw_hs, w_hs, resp_hs;

   // ------------------------------------------------------------------
   // Address decode: scan from the top slot down so the lowest matching
   // index is the one left standing. No match leaves dec_sel all-zero.
   // ------------------------------------------------------------------
   always_comb begin
      dec_sel = '0;
      dec_hit = 1'b0;
      for (int i = int'(NS) - 1; i >= 0; i--) begin
         if ((mst_axil.aw_addr & IC_SLAVE_ADDR_MASK[i]) == IC_SLAVE_BASE_ADDR[i]) begin
            dec_sel    = '0;
            dec_sel[i] = 1'b1;
            dec_hit    = 1'b1;
         end
      end
   end

   // B response of the selected slot (sel_q is one-hot, so OR-reduce).
   always_comb begin
      resp_mux = '0;
      for (int i = 0; i < int'(NS); i++) begin
         if (sel_q[i]) resp_mux = resp_mux | cbar_resp_data_i[i];
      end
   end

   // ------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      wbuf_d    = wbuf_q;
      w_full_d  = w_full_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      bresp_d   = bresp_q;

      aw_ready  = 1'b0;
      b_valid   = 1'b0;
      aw_val    = '0;
      w_val     = '0;
      resp_rdy  = '0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      resp_hs   = 1'b0;

      // The W beat may land in any pre-response state, independent of AW.
      w_ready = !w_full_q &&
                (state_q == ST_IDLE || state_q == ST_SEND || state_q == ST_DECERR);
      if (mst_axil.w_valid && w_ready) begin
         wbuf_d   = {mst_axil.w_strb, mst_axil.w_data};
         w_full_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            aw_ready = 1'b1;
            if (mst_axil.aw_valid) begin
               addr_d  = mst_axil.aw_addr;
               sel_d   = dec_sel;
               // The DECERR state itself records the decode miss.
               state_d = dec_hit ? ST_SEND : ST_DECERR;
            end
         end

         ST_SEND: begin
            // AW is offered from the first SEND cycle, so W can never be
            // presented to the slot ahead of AW.
            if (!aw_done_q)             aw_val = sel_q;
            if (w_full_q && !w_done_q)  w_val  = sel_q;
            aw_hs = |(aw_val & cbar_aw_reqst_rdy_i);
            w_hs  = |(w_val  & cbar_w_reqst_rdy_i);
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            // Move on in the same edge as the last outstanding handshake.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_RESP;
         end

         ST_DECERR: begin
            // W must still be consumed so the master sees a complete write.
            if (w_full_q) begin
               bresp_d = {IC_BRESP_WIDTH{1'b1}};
               state_d = ST_BRESP;
            end
         end

         ST_RESP: begin
            resp_rdy = sel_q;
            resp_hs  = |(cbar_resp_val_i & sel_q);
            if (resp_hs) begin
               bresp_d = resp_mux;
               state_d = ST_BRESP;
            end
         end

         ST_BRESP: begin
            b_valid = 1'b1;
            if (mst_axil.b_ready) begin
               w_full_d  = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         sel_q     <= '0;
         wbuf_q    <= '0;
         w_full_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         wbuf_q    <= wbuf_d;
         w_full_q  <= w_full_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         bresp_q   <= bresp_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mst_axil.aw_ready = aw_ready;
   assign mst_axil.w_ready  = w_ready;
   assign mst_axil.b_valid  = b_valid;
   assign mst_axil.b_resp   = bresp_q;

   assign cbar_aw_reqst_val_o = aw_val;
   assign cbar_w_reqst_val_o  = w_val;
   assign cbar_resp_rdy_o     = resp_rdy;

   // Payloads go to every slot; only the one-hot valid steers them.
   for (genvar g = 0; g < int'(NS); g++) begin : g_bcast
      assign cbar_aw_reqst_data_o[g] = addr_q;
      assign cbar_w_reqst_data_o[g]  = wbuf_q;
   end

endmodule

// File: tb/tb_liteic_master_node_write.sv
// Testbench for liteic_master_node_write: directed vector table plus random
// writes, each checked against a transaction-level model of the decode map,
// handshake latencies and response routing.
module tb_liteic_master_node_write;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   axi_lite_if #(.ADDR_W(32), .DATA_W(32), .RESP_W(2)) axil ();

   logic [NS-1:0][31:0] aw_data;
   logic [NS-1:0]       aw_val, aw_rdy;
   logic [NS-1:0][35:0] w_data;
   logic [NS-1:0]       w_val, w_rdy;
   logic [NS-1:0]       rsp_val, rsp_rdy;
   logic [NS-1:0][1:0]  rsp_data;

   liteic_master_node_write dut (
      .clk_i                (clk),
      .rstn_i               (rstn),
      .mst_axil             (axil),
      .cbar_aw_reqst_data_o (aw_data),
      .cbar_aw_reqst_val_o  (aw_val),
      .cbar_aw_reqst_rdy_i  (aw_rdy),
      .cbar_w_reqst_data_o  (w_data),
      .cbar_w_reqst_val_o   (w_val),
      .cbar_w_reqst_rdy_i   (w_rdy),
      .cbar_resp_val_i      (rsp_val),
      .cbar_resp_data_i     (rsp_data),
      .cbar_resp_rdy_o      (rsp_rdy)
   );

   // One write: stimulus timing, slot behaviour and expected outcome.
   typedef struct {
      string       nm;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_cyc;     // cycle master raises AW valid
      int          w_cyc;      // cycle master raises W valid
      int          aw_wait;    // slot AW-ready stall cycles
      int          w_wait;     // slot W-ready stall cycles
      int          resp_wait;  // slot B delay after both handshakes
      int          b_wait;     // master B-ready stall cycles
      logic [1:0]  resp;       // slot response
      bit          decoy;      // spurious B valid on a neighbouring slot
      int          exp_slot;   // -1 = unmapped
      logic [1:0]  exp_bresp;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int slot_of(input logic [NS-1:0] m);
      int r = -1;
      for (int i = NS - 1; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   // Address map: slot i owns addresses whose top nibble equals i.
   function automatic int ref_slot(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & 32'hF000_0000) == (32'(i) << 28)) return i;
      return -1;
   endfunction

   task automatic drive_idle();
      axil.aw_valid = 1'b0; axil.aw_addr = '0;
      axil.w_valid  = 1'b0; axil.w_data  = '0; axil.w_strb = '0;
      axil.b_ready  = 1'b0;
      aw_rdy = '0; w_rdy = '0; rsp_val = '0; rsp_data = '0;
   endtask

   task automatic chk_reset(input string p);
      chk({p, ".aw_val"},   aw_val,        0);
      chk({p, ".w_val"},    w_val,         0);
      chk({p, ".rsp_rdy"},  rsp_rdy,       0);
      chk({p, ".b_valid"},  axil.b_valid,  0);
      chk({p, ".b_resp"},   axil.b_resp,   0);
      chk({p, ".aw_ready"}, axil.aw_ready, 1);
      chk({p, ".w_ready"},  axil.w_ready,  1);
   endtask

   // Runs one write; entered and left just after a rising edge.
   task automatic run_write(input vec_t v);
      int cyc = 0, av_cnt = 0, wv_cnt = 0, viol = 0, s;
      int aw_hs = -1, w_hs = -1, caw_hs = -1, cw_hs = -1, rsp_hs = -1, bv_first = -1;
      int cav_first = -1, cwv_first = -1, aw_slot = -1, w_slot = -1;
      logic [31:0] got_addr = '0;
      logic [35:0] got_w = '0;
      logic [1:0]  got_b = '0;
      logic [NS-1:0] one_s;
      bit done = 0;
      while (!done && cyc < 100) begin
         axil.aw_valid = (aw_hs < 0) && (cyc >= v.aw_cyc);
         axil.aw_addr  = v.addr;
         axil.w_valid  = (w_hs < 0) && (cyc >= v.w_cyc);
         axil.w_data   = v.data;
         axil.w_strb   = v.strb;
         aw_rdy  = (av_cnt >= v.aw_wait) ? '1 : '0;
         w_rdy   = (wv_cnt >= v.w_wait)  ? '1 : '0;
         rsp_val = '0;
         rsp_data = {NS{v.resp ^ 2'b11}};
         if (caw_hs >= 0 && cw_hs >= 0 && rsp_hs < 0 && aw_slot >= 0) begin
            if (v.decoy) rsp_val[(aw_slot + 1) % NS] = 1'b1;
            if (cyc - imax(caw_hs, cw_hs) - 1 >= v.resp_wait) begin
               rsp_val[aw_slot]  = 1'b1;
               rsp_data[aw_slot] = v.resp;
            end
         end
         axil.b_ready = (bv_first < 0) ? (v.b_wait == 0) : (cyc - bv_first >= v.b_wait);

         @(negedge clk);
         // master-side readiness: open until that channel's beat is taken
         if (axil.aw_ready !== (aw_hs < 0)) viol++;
         if (axil.w_ready  !== (w_hs < 0))  viol++;
         if (axil.aw_valid && axil.aw_ready) aw_hs = cyc;
         if (axil.w_valid && axil.w_ready)   w_hs  = cyc;

         if (aw_val != '0) begin
            if (!$onehot(aw_val) || caw_hs >= 0) viol++;
            s = slot_of(aw_val);
            if (cav_first >= 0 && (s != aw_slot || aw_data[s] != got_addr)) viol++;
            if (cav_first < 0) cav_first = cyc;
            aw_slot = s; got_addr = aw_data[s]; av_cnt++;
            if ((aw_val & aw_rdy) != '0) caw_hs = cyc;
         end else if (cav_first >= 0 && caw_hs < 0) viol++;

         if (w_val != '0) begin
            if (!$onehot(w_val) || cw_hs >= 0 || cav_first < 0) viol++;
            s = slot_of(w_val);
            if (cwv_first >= 0 && (s != w_slot || w_data[s] != got_w)) viol++;
            if (cwv_first < 0) cwv_first = cyc;
            w_slot = s; got_w = w_data[s]; wv_cnt++;
            if ((w_val & w_rdy) != '0) cw_hs = cyc;
         end else if (cwv_first >= 0 && cw_hs < 0) viol++;

         if (rsp_rdy != '0) begin
            one_s = '0;
            if (aw_slot >= 0) one_s[aw_slot] = 1'b1;
            if (rsp_hs >= 0 || rsp_rdy != one_s || caw_hs < 0 || cw_hs < 0) viol++;
            if (aw_slot >= 0 && rsp_val[aw_slot] && rsp_rdy[aw_slot]) rsp_hs = cyc;
         end

         if (axil.b_valid) begin
            if (bv_first < 0) begin
               bv_first = cyc;
               got_b    = axil.b_resp;
            end else if (axil.b_resp !== got_b) viol++;
            if (axil.b_ready) done = 1;
         end else if (bv_first >= 0) viol++;

         @(posedge clk); #1;
         cyc++;
      end
      drive_idle();
      @(negedge clk);
      chk({v.nm, ".done"},        done,          1);
      chk({v.nm, ".aw_rdy_next"}, axil.aw_ready, 1);
      chk({v.nm, ".aw_slot"},     aw_slot,       v.exp_slot);
      chk({v.nm, ".w_slot"},      w_slot,        v.exp_slot);
      chk({v.nm, ".bresp"},       got_b,         v.exp_bresp);
      chk({v.nm, ".protocol"},    viol,          0);
      if (v.exp_slot >= 0) begin
         chk({v.nm, ".addr"},   got_addr,  v.addr);
         chk({v.nm, ".wdata"},  got_w,     {v.strb, v.data});
         chk({v.nm, ".aw_lat"}, cav_first, aw_hs + 1);
         chk({v.nm, ".w_lat"},  cwv_first, imax(aw_hs, w_hs) + 1);
         chk({v.nm, ".b_lat"},  bv_first,  rsp_hs + 1);
      end else begin
         chk({v.nm, ".b_lat"},  bv_first,  imax(aw_hs, w_hs) + 2);
      end
      @(posedge clk); #1;
   endtask

   vec_t tbl[8];
   vec_t r;
   logic [3:0] nib;
   int n;

   initial begin
      //          nm            addr          data          strb   awc wc awW wW rW bW resp  dec slot bresp
      tbl[0] = '{"mapped",    32'h1000_0040, 32'hDEAD_BEEF, 4'hF,  0, 0, 0, 0, 2, 0, 2'b00, 0,  1, 2'b00};
      tbl[1] = '{"w_first",   32'h3000_0000, 32'h0123_4567, 4'h3,  3, 0, 0, 0, 0, 0, 2'b00, 0,  3, 2'b00};
      tbl[2] = '{"unmapped",  32'hF000_0000, 32'hCAFE_F00D, 4'hF,  0, 0, 0, 0, 0, 0, 2'b00, 0, -1, 2'b11};
      tbl[3] = '{"unmap_wl",  32'h4000_0000, 32'h0000_0001, 4'h1,  0, 2, 0, 0, 0, 1, 2'b00, 0, -1, 2'b11};
      tbl[4] = '{"backpr",    32'h2000_0010, 32'hA5A5_5A5A, 4'hC,  0, 0, 5, 9, 1, 0, 2'b10, 0,  2, 2'b10};
      tbl[5] = '{"bready",    32'h0FFF_FFFC, 32'h5555_AAAA, 4'h1,  0, 0, 0, 0, 0, 4, 2'b01, 1,  0, 2'b01};
      tbl[6] = '{"w_late",    32'h2000_0000, 32'h8765_4321, 4'h6,  0, 2, 1, 0, 0, 1, 2'b11, 1,  2, 2'b11};
      tbl[7] = '{"zero_wait", 32'h0000_0000, 32'hFFFF_0000, 4'h8,  0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 2'b00};

      rstn = 1'b0;
      drive_idle();
      #12;
      chk_reset("reset0");
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_write(tbl[i]);

      // Reset while waiting for the slot response.
      axil.aw_valid = 1'b1; axil.aw_addr = 32'h1000_0000;
      axil.w_valid  = 1'b1; axil.w_data  = 32'h1111_2222; axil.w_strb = 4'hF;
      aw_rdy = '1; w_rdy = '1; rsp_val = '0;
      @(posedge clk); #1;
      axil.aw_valid = 1'b0; axil.w_valid = 1'b0;
      n = 0;
      while (rsp_rdy == '0 && n < 10) begin @(posedge clk); #1; n++; end
      chk("midrst.in_resp", rsp_rdy, 4'b0010);
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      chk_reset("midrst");
      drive_idle();
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      run_write(tbl[0]);

      // Random writes checked against the address-map model.
      for (int k = 0; k < 40; k++) begin
         nib = 4'($urandom_range(0, 5));
         if (nib > 4'd3) nib = 4'($urandom_range(4, 15));
         r.nm        = $sformatf("rnd%0d", k);
         r.addr      = {nib, 28'($urandom)};
         r.data      = $urandom;
         r.strb      = 4'($urandom);
         r.aw_cyc    = $urandom_range(0, 3);
         r.w_cyc     = $urandom_range(0, 3);
         r.aw_wait   = $urandom_range(0, 3);
         r.w_wait    = $urandom_range(0, 3);
         r.resp_wait = $urandom_range(0, 3);
         r.b_wait    = $urandom_range(0, 2);
         r.resp      = 2'($urandom);
         r.decoy     = 1'($urandom);
         r.exp_slot  = ref_slot(r.addr);
         r.exp_bresp = (r.exp_slot < 0) ? 2'b11 : r.resp;
         run_write(r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
